hwag_coil_sched: RTL
====================

// Module: hwag_coil_sched
// PURPOSE
// - Multi-channel ignition-coil scheduler downstream of the angle generator; consumes its interpolated angle count (acnt2).
// - Each channel drives its coil from a set (dwell start) angle to a reset (spark) angle.
// - Angles are CPU-written into shadow registers and applied atomically at angle wrap (MAX_ACR -> 0).
// - A per-channel dwell timeout forces the coil off if the reset angle is never reached.
// PARAMETERS
// - CH_NUM    4           number of coil channels
// - ANGLE_W   24          angle count width
// - MAX_ACR   24'd3839    last angle count before wrap
// - DWELL_W   20          dwell timeout counter width
// - DWELL_MAX 20'd400000  max coil-on time in clk cycles
// PORTS
// - clk       in   1                    system clock
// - rst       in   1                    asynchronous reset, active-high
// - run       in   1                    angle generator synchronised (hwag_start)
// - acnt      in   ANGLE_W              current angle count
// - wr_valid  in   1                    shadow write request
// - wr_ready  out  1                    shadow write accepted when wr_valid & wr_ready
// - wr_ch     in   $clog2(CH_NUM)       target channel
// - wr_set    in   ANGLE_W              new set angle
// - wr_reset  in   ANGLE_W              new reset angle
// - wr_err    out  1                    one-clk pulse: write rejected
// - fault_clr in   CH_NUM               per-channel sticky fault clear
// - coil_out  out  CH_NUM               coil drive, 1 = dwell
// - fault     out  CH_NUM               sticky dwell-timeout fault
// BEHAVIOUR
// - Reset: coil_out=0, fault=0, wr_ready=1, wr_err=0; shadow and active set/reset = 0; acnt_q=0; timers=0.
// - acnt is registered once (acnt_q).
// - step   = run & (acnt != acnt_q).
// - wrap   = step & (acnt_q == MAX_ACR) & (acnt == 0).
// - Transfer: on wrap, all shadow -> active in the same clk.
//   - wr_ready=0 combinationally in that clk, so no write races a transfer.
// - While run=0: active tracks shadow every clk and coil_out is forced 0.
// - Write: handshake accepted -> shadow[wr_ch] updated next clk.
//   - Rejected when wr_set > MAX_ACR, wr_reset > MAX_ACR, or wr_ch >= CH_NUM.
//   - On reject: shadow unchanged, wr_err=1 for one clk.
// - Channel: on step with acnt == active_set, coil_out goes 1 next clk.
//   - On step with acnt == active_reset, coil_out goes 0 next clk.
//   - set == reset: reset wins, channel stays off.
//   - Latency: 1 clk from acnt change to coil_out change.
//   - The window may span wrap (set > reset); it is handled naturally by equality events.
// - Dwell timer: counts clks while coil_out=1 and clears when coil_out=0.
//   - At count == DWELL_MAX-1: coil_out=0 and fault=1 next clk.
//   - Channel is inhibited (ignores set events) while fault=1.
//   - fault_clr[i]=1 clears fault[i]; if simultaneous with timeout, the timeout wins.
// - run falling mid-dwell: coil_out=0 next clk, timer cleared, fault unchanged.
// - Non-consecutive acnt jump (resync): no wrap detected unless exactly MAX_ACR -> 0.
//   - Equality events still fire on the new value.
// - rst mid-operation: all state returns to reset values immediately (async).
// STRUCTURE
// - Shared package hwag_pkg: ANGLE_W, HWAMAXACR (3839), HWASTWD, angle_t typedef (logic [ANGLE_W-1:0]).
// - Sub-module hwag_coil_chan, instantiated CH_NUM times via generate.
//   - Holds shadow/active regs, set/reset compare, coil flip-flop, dwell timer and fault.
// - Top level: acnt register, step/wrap detect, write decode/validation, wr_ready/wr_err.
// TESTING
// - Write ch0 set=32 reset=96, run=1, sweep acnt 0..3839 -> 0.
//   - No output in the first rev (shadow only); second rev: coil_out[0] rises 1 clk after acnt=32, falls 1 clk after acnt=96.
// - Write ch1 set=3800 reset=20 -> coil_out[1] high from 3800 across the wrap, low 1 clk after acnt=20.
// - Hold acnt at 50 with ch0 set=32 reset=96 and DWELL_MAX=100 -> coil_out[0] drops after 100 clks.
//   - fault[0]=1; set events ignored until fault_clr[0].
// - wr_set=3840 -> wr_err pulse, shadow unchanged.
//   - wr_valid asserted in the wrap clk -> wr_ready=0; write lands the next clk and applies only at the following wrap.
// - Deassert run mid-dwell -> coil_out=0 next clk.
//   - Assert rst mid-dwell -> all outputs 0 immediately, shadow cleared.

Source files
------------

// File: rtl/hwag_pkg.sv
// hwag_pkg: shared definitions for the angle generator family.
//   ANGLE_W    width of an angle count
//   HWAMAXACR  last angle count of one revolution before wrap to 0
//   HWASTWD    bits needed to hold one revolution of angle counts
//   angle_t    angle count type
//   chan_state_e  coil channel state: off, dwelling, latched in fault
package hwag_pkg;

  localparam int ANGLE_W = 24;
  localparam logic [ANGLE_W-1:0] HWAMAXACR = 24'd3839;
  localparam int HWASTWD = 12;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic [1:0] {
    CH_OFF   = 2'd0,
    CH_DWELL = 2'd1,
    CH_FAULT = 2'd2
  } chan_state_e;

  // True when an angle lies inside one revolution.
  function automatic logic angle_in_range(angle_t a, angle_t max_acr);
    return a <= max_acr;
  endfunction

endpackage

// File: rtl/hwag_coil_chan.sv
// hwag_coil_chan: one ignition-coil channel.
// Holds the shadow and active set/reset angles, detects set/reset angle
// events, drives the coil and guards the dwell with a timeout that latches
// a sticky fault.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   run         angle generator synchronised
//   step, wrap  angle advanced this clk / angle wrapped MAX_ACR -> 0
//   acnt        current (unregistered) angle count
//   wr_en       load wr_set/wr_reset into the shadow registers
//   fault_clr   clear the sticky fault
//   coil        coil drive, 1 = dwell
//   fault       sticky dwell-timeout fault
module hwag_coil_chan #(
  parameter int ANGLE_W = hwag_pkg::ANGLE_W,
  parameter int DWELL_W = 20,
  parameter logic [DWELL_W-1:0] DWELL_MAX = 20'd400000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic               wrap,
  input  logic [ANGLE_W-1:0] acnt,
  input  logic               wr_en,
  input  logic [ANGLE_W-1:0] wr_set,
  input  logic [ANGLE_W-1:0] wr_reset,
  input  logic               fault_clr,
  output logic               coil,
  output logic               fault
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_MAX - 1'b1);

  logic [ANGLE_W-1:0] shadow_set;
  logic [ANGLE_W-1:0] shadow_reset;
  logic [ANGLE_W-1:0] active_set;
  logic [ANGLE_W-1:0] active_reset;
  logic [DWELL_W-1:0] timer;
  logic               set_hit;
  logic               reset_hit;
  logic               timeout;

  hwag_pkg::chan_state_e state;
  hwag_pkg::chan_state_e state_next;

  assign set_hit   = step & (acnt == active_set);
  assign reset_hit = step & (acnt == active_reset);
  assign timeout   = (state == hwag_pkg::CH_DWELL) & (timer == DWELL_LAST);

  // Shadow takes CPU writes; active picks up the shadow atomically at wrap,
  // and follows it continuously while the angle generator is not running so
  // the first revolution after sync already uses the latest angles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_set   <= '0;
      shadow_reset <= '0;
      active_set   <= '0;
      active_reset <= '0;
    end else begin
      if (wr_en) begin
        shadow_set   <= wr_set;
        shadow_reset <= wr_reset;
      end
      if (!run || wrap) begin
        active_set   <= shadow_set;
        active_reset <= shadow_reset;
      end
    end
  end

  // State register plus dwell timer. The timer only runs across consecutive
  // dwell clks, so it is zero on every dwell entry and after any exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= hwag_pkg::CH_OFF;
      timer <= '0;
    end else begin
      state <= state_next;
      if (state == hwag_pkg::CH_DWELL && state_next == hwag_pkg::CH_DWELL) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end
    end
  end

  // Next-state logic. Reset angle beats set angle when both hit together, a
  // timeout beats a simultaneous fault clear (fault_clr is only honoured in
  // the fault state), and set events are ignored while the fault is latched.
  always_comb begin
    state_next = state;
    case (state)
      hwag_pkg::CH_OFF: begin
        if (set_hit && !reset_hit) begin
          state_next = hwag_pkg::CH_DWELL;
        end
      end
      hwag_pkg::CH_DWELL: begin
        if (!run) begin
          state_next = hwag_pkg::CH_OFF;
        end else if (timeout) begin
          state_next = hwag_pkg::CH_FAULT;
        end else if (reset_hit) begin
          state_next = hwag_pkg::CH_OFF;
        end
      end
      hwag_pkg::CH_FAULT: begin
        if (fault_clr) begin
          state_next = hwag_pkg::CH_OFF;
        end
      end
      default: state_next = hwag_pkg::CH_OFF;
    endcase
  end

  assign coil  = (state == hwag_pkg::CH_DWELL);
  assign fault = (state == hwag_pkg::CH_FAULT);

endmodule

// File: rtl/hwag_coil_sched.sv
// hwag_coil_sched: multi-channel ignition-coil scheduler driven by the
// interpolated angle count of the angle generator.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   run         angle generator synchronised
//   acnt        current angle count
//   wr_valid / wr_ready   shadow write handshake
//   wr_ch, wr_set, wr_reset  target channel and new angles
//   wr_err      one-clk pulse when a write is rejected
//   fault_clr   per-channel sticky fault clear
//   coil_out    coil drive per channel, 1 = dwell
//   fault       sticky dwell-timeout fault per channel
module hwag_coil_sched #(
  parameter int CH_NUM  = 4,
  parameter int ANGLE_W = hwag_pkg::ANGLE_W,
  parameter logic [ANGLE_W-1:0] MAX_ACR = hwag_pkg::HWAMAXACR,
  parameter int DWELL_W = 20,
  parameter logic [DWELL_W-1:0] DWELL_MAX = 20'd400000,
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [ANGLE_W-1:0] acnt,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [ANGLE_W-1:0] wr_set,
  input  logic [ANGLE_W-1:0] wr_reset,
  output logic               wr_err,
  input  logic [CH_NUM-1:0]  fault_clr,
  output logic [CH_NUM-1:0]  coil_out,
  output logic [CH_NUM-1:0]  fault
);

  logic [ANGLE_W-1:0] acnt_q;
  logic               step;
  logic               wrap;
  logic               wr_accept;
  logic               wr_ch_ok;
  logic               wr_bad;

  // Previous angle count, used to see the angle move and to spot the wrap.
  // A rejected write is reported one clk after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acnt_q <= '0;
      wr_err <= 1'b0;
    end else begin
      acnt_q <= acnt;
      wr_err <= wr_accept & wr_bad;
    end
  end

  // Only an exact MAX_ACR -> 0 move counts as a wrap; a resync jump that
  // lands on 0 from anywhere else does not transfer the shadow angles.
  assign step = run & (acnt != acnt_q);
  assign wrap = step & (acnt_q == MAX_ACR) & (acnt == '0);

  // Holding off writes in the wrap clk keeps a write from racing the
  // shadow-to-active transfer.
  assign wr_ready  = ~wrap;
  assign wr_accept = wr_valid & wr_ready;
  assign wr_ch_ok  = (32'(wr_ch) < CH_NUM);
  assign wr_bad    = (wr_set > MAX_ACR) | (wr_reset > MAX_ACR) | ~wr_ch_ok;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    hwag_coil_chan #(
      .ANGLE_W   (ANGLE_W),
      .DWELL_W   (DWELL_W),
      .DWELL_MAX (DWELL_MAX)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .step      (step),
      .wrap      (wrap),
      .acnt      (acnt),
      .wr_en     (wr_accept & ~wr_bad & (32'(wr_ch) == i)),
      .wr_set    (wr_set),
      .wr_reset  (wr_reset),
      .fault_clr (fault_clr[i]),
      .coil      (coil_out[i]),
      .fault     (fault[i])
    );
  end

endmodule
